// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, registered syncs
// and strobes, plus a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CLK_DIV   = 1,
    parameter int FRAME_W   = 8,
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame
);

    localparam int   DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HP = (H_POL != 0);
    localparam logic VP = (V_POL != 0);

    logic [DW-1:0]      r_div;
    logic [HW-1:0]      r_hpos;
    logic [VW-1:0]      r_vpos;
    logic [FRAME_W-1:0] r_frame;
    logic               r_hs;
    logic               r_vs;
    logic               r_de;
    logic               r_pix;
    logic               r_ls;
    logic               r_fs;

    logic               w_div_end;
    logic               w_adv;
    logic               w_h_end;
    logic               w_v_end;
    logic [DW-1:0]      w_div_nxt;
    logic [HW-1:0]      w_h_nxt;
    logic [VW-1:0]      w_v_nxt;
    logic [FRAME_W-1:0] w_f_nxt;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_de;

    always_comb begin
        w_div_end = (r_div == DW'(CLK_DIV - 1));
        w_adv     = ena && w_div_end;
        w_h_end   = (r_hpos == HW'(H_TOTAL - 1));
        w_v_end   = (r_vpos == VW'(V_TOTAL - 1));
        w_div_nxt = r_div;
        w_h_nxt   = r_hpos;
        w_v_nxt   = r_vpos;
        w_f_nxt   = r_frame;
        if (ena) begin
            w_div_nxt = w_div_end ? '0 : r_div + 1'b1;
        end
        if (w_adv) begin
            if (w_h_end) begin
                w_h_nxt = '0;
                if (w_v_end) begin
                    w_v_nxt = '0;
                    w_f_nxt = r_frame + 1'b1;
                end else begin
                    w_v_nxt = r_vpos + 1'b1;
                end
            end else begin
                w_h_nxt = r_hpos + 1'b1;
            end
        end
        // Decode from the next counter values so flopped syncs line up with hpos/vpos
        w_hs_act = (w_h_nxt >= HW'(H_ACTIVE + H_FRONT)) &&
                   (w_h_nxt <  HW'(H_ACTIVE + H_FRONT + H_SYNC));
        w_vs_act = (w_v_nxt >= VW'(V_ACTIVE + V_FRONT)) &&
                   (w_v_nxt <  VW'(V_ACTIVE + V_FRONT + V_SYNC));
        w_de     = (w_h_nxt < HW'(H_ACTIVE)) && (w_v_nxt < VW'(V_ACTIVE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_hpos  <= '0;
            r_vpos  <= '0;
            r_frame <= '0;
            r_pix   <= 1'b0;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
            r_de    <= 1'b1;
            r_hs    <= ~HP;
            r_vs    <= ~VP;
        end else begin
            r_div   <= w_div_nxt;
            r_hpos  <= w_h_nxt;
            r_vpos  <= w_v_nxt;
            r_frame <= w_f_nxt;
            r_pix   <= w_adv;
            r_ls    <= w_adv && w_h_end;
            r_fs    <= w_adv && w_h_end && w_v_end;
            r_de    <= w_de;
            r_hs    <= w_hs_act ? HP : ~HP;
            r_vs    <= w_vs_act ? VP : ~VP;
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign frame       = r_frame;
    assign pix_en      = r_pix;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign display_on  = r_de;
    assign hsync       = r_hs;
    assign vsync       = r_vs;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels, each >= 1.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines, each >= 1.
REQ-005 SHALL have parameters H_POL and V_POL, default 0 each; 0 = sync active-low, 1 = active-high.
REQ-006 SHALL have parameter CLK_DIV, default 1, range 1..16; clocks per pixel.
REQ-007 SHALL have parameter FRAME_W, default 8, frame counter width.
REQ-008 SHALL derive H_TOTAL = sum of H_* widths, V_TOTAL = sum of V_* widths, HW = clog2(H_TOTAL), VW = clog2(V_TOTAL).
REQ-009 clk  input  1  single clock; all state changes on its rising edge.
REQ-010 rst_n  input  1  synchronous active-low reset.
REQ-011 ena  input  1  run enable; low freezes all counters.
REQ-012 hpos  output  HW  current pixel column.
REQ-013 vpos  output  VW  current line.
REQ-014 hsync  output  1  horizontal sync, polarity per H_POL.
REQ-015 vsync  output  1  vertical sync, polarity per V_POL.
REQ-016 display_on  output  1  high when hpos < H_ACTIVE and vpos < V_ACTIVE.
REQ-017 pix_en  output  1  one-clock strobe marking a pixel advance.
REQ-018 line_start  output  1  one-clock pulse when hpos first shows 0.
REQ-019 frame_start  output  1  one-clock pulse when hpos and vpos first show 0 together.
REQ-020 frame  output  FRAME_W  completed-frame counter.

Function
REQ-021 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-022 Divider SHALL count 0..CLK_DIV-1 while ena=1; pix_en SHALL be high in the cycle after the divider reaches CLK_DIV-1; CLK_DIV=1 gives pix_en=1 every cycle ena=1.
REQ-023 Each cycle with pix_en=1, hpos SHALL advance by 1; hpos = H_TOTAL-1 SHALL wrap to 0 and advance vpos by 1.
REQ-024 vpos = V_TOTAL-1 with hpos wrap SHALL wrap vpos to 0 and increment frame modulo 2^FRAME_W (2^FRAME_W-1 -> 0).
REQ-025 hsync SHALL be active exactly while H_ACTIVE+H_FRONT <= hpos < H_ACTIVE+H_FRONT+H_SYNC, in the same cycle as that hpos value.
REQ-026 vsync SHALL be active exactly while V_ACTIVE+V_FRONT <= vpos < V_ACTIVE+V_FRONT+V_SYNC, independent of hpos.
REQ-027 display_on, hsync and vsync SHALL be computed from next-state counters so they align with hpos/vpos on the same cycle.
REQ-028 line_start SHALL pulse for exactly one clock on each hpos wrap to 0; frame_start SHALL pulse on the same clock when vpos also wraps to 0.
REQ-029 ena=0 SHALL hold divider, hpos, vpos, frame, hsync, vsync, display_on; pix_en, line_start, frame_start SHALL be 0; resuming continues from held state without skip.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set divider=0, hpos=0, vpos=0, frame=0, pix_en=0, line_start=0, frame_start=0, display_on=1, hsync=!H_POL, vsync=!V_POL.
REQ-031 Reset SHALL take priority over ena and over any in-progress wrap; no start pulse SHALL be produced by reset release.
REQ-032 Reset asserted mid-frame SHALL restart timing at (0,0) on the next edge; frame SHALL restart at 0.

Verification
REQ-033 Defaults, ena=1, release reset: after 800 clocks hpos=0, vpos=1, line_start=1 for one clock, frame_start=0.
REQ-034 Defaults: hsync=0 exactly for hpos 656..751 each line; vsync=0 exactly for vpos 490..491; display_on=0 at hpos 640 and at vpos 480.
REQ-035 Defaults: after 420000 clocks from reset, hpos=0, vpos=0, frame=1, frame_start=1 and line_start=1 on the same clock.
REQ-036 CLK_DIV=3: hpos advances every third clock; pix_en duty 1/3; line length 2400 clocks.
REQ-037 H/V widths 4/1/1/1 and 3/1/1/1, FRAME_W=2, H_POL=V_POL=1: hsync high only at hpos 5, vsync high only at vpos 4; frame wraps 3->0 after 4 frames (168 clocks).
REQ-038 ena=0 for 10 clocks at hpos=100, then rst_n=0 one clock mid-frame: counters hold at 100 with no strobes, then return to hpos=0, vpos=0, frame=0, hsync=vsync=1 (defaults).
